rx_deframer: RTL and testbench

RX_DEFRAMER -- requirements
Module: rx_deframer

---
 rtl/rx_deframer_pkg.sv | 23 ++
 rtl/crc8_calc.sv | 35 +++
 rtl/rx_deframer.sv | 196 +++++++++++++++++++
 tb/tb_rx_deframer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_deframer_pkg.sv
// rtl/rx_deframer_pkg.sv - shared constants, FSM encoding and CRC-8 step for rx_deframer
package rx_deframer_pkg;

    localparam logic [47:0] FAS_PATTERN = 48'hF6F6F6282828;
    localparam logic [7:0]  CRC8_POLY   = 8'h07;

    localparam logic [2:0] ST_HUNT      = 3'd0;
    localparam logic [2:0] ST_PYLD      = 3'd1;
    localparam logic [2:0] ST_CRC       = 3'd2;
    localparam logic [2:0] ST_RESOLVE   = 3'd3;
    localparam logic [2:0] ST_ACK_DRAIN = 3'd4;

    // MSB-first, non-reflected CRC-8 over one byte
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_calc.sv
// rtl/crc8_calc.sv - running CRC-8 register with clear and byte enable
module crc8_calc
    import rx_deframer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_update(crc_q, data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - serial FAS-aligned frame receiver with CRC check, ACK and payload drain (macro RX_DEFRAMER_CRC_CHECK_EN)
module rx_deframer
    import rx_deframer_pkg::*;
#(
    parameter int PYLD_BYTES = 16,
    parameter int ACK_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_otn_rx_data,
    output logic       o_otn_tx_ack,
    output logic [7:0] o_pyld_data,
    output logic       o_pyld_data_valid,
    input  logic       i_pyld_data_ready,
    output logic [7:0] o_crc_val,
    output logic       o_crc_err,
    output logic       o_in_frame
);

    localparam int IDX_W = (PYLD_BYTES > 1) ? $clog2(PYLD_BYTES) : 1;
    localparam int ACK_W = $clog2(ACK_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PYLD_BYTES - 1);

    logic [2:0]       state_q, state_d;
    logic [47:0]      fas_sr_q, fas_sr_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_sr_q, byte_sr_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]       crc_val_q, crc_val_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic [IDX_W-1:0] drain_idx_q, drain_idx_d;
    logic             drain_done_q, drain_done_d;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
    logic [7:0]       rx_crc_q, rx_crc_d;
    logic             crc_err_q, crc_err_d;
`endif

    logic [7:0] buf_q [PYLD_BYTES];
    logic       buf_we;
    logic       crc_clr;
    logic       crc_en;
    logic [7:0] rx_byte;
    logic [7:0] crc_out;
    logic       pyld_valid;

    crc8_calc u_crc8_calc (
        .clk  (i_clk),
        .rst  (i_rst),
        .clr  (crc_clr),
        .en   (crc_en),
        .data (rx_byte),
        .crc  (crc_out)
    );

    assign rx_byte    = {byte_sr_q[6:0], i_otn_rx_data};
    assign pyld_valid = (state_q == ST_ACK_DRAIN) && !drain_done_q;

    always_comb begin
        state_d      = state_q;
        fas_sr_d     = fas_sr_q;
        bit_cnt_d    = bit_cnt_q;
        byte_sr_d    = byte_sr_q;
        byte_idx_d   = byte_idx_q;
        crc_val_d    = crc_val_q;
        ack_cnt_d    = (ack_cnt_q != '0) ? ack_cnt_q - ACK_W'(1) : '0;
        drain_idx_d  = drain_idx_q;
        drain_done_d = drain_done_q;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
        rx_crc_d     = rx_crc_q;
        crc_err_d    = 1'b0;
`endif
        buf_we       = 1'b0;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;

        case (state_q)
            ST_HUNT: begin
                fas_sr_d = {fas_sr_q[46:0], i_otn_rx_data};
                if (fas_sr_d == FAS_PATTERN) begin
                    state_d    = ST_PYLD;
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = '0;
                    crc_clr    = 1'b1;
                end
            end
            ST_PYLD: begin
                byte_sr_d = rx_byte;
                bit_cnt_d = (bit_cnt_q == 3'd7) ? 3'd0 : bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    buf_we = 1'b1;
                    crc_en = 1'b1;
                    if (byte_idx_q == LAST_IDX) begin
                        state_d    = ST_CRC;
                        byte_idx_d = '0;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CRC: begin
                byte_sr_d = rx_byte;
                bit_cnt_d = (bit_cnt_q == 3'd7) ? 3'd0 : bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
`ifdef RX_DEFRAMER_CRC_CHECK_EN
                    rx_crc_d = rx_byte;
`endif
                    state_d  = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                crc_val_d    = crc_out;
                state_d      = ST_ACK_DRAIN;
                ack_cnt_d    = ACK_W'(ACK_CYCLES);
                drain_idx_d  = '0;
                drain_done_d = 1'b0;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
                if (crc_out != rx_crc_q) begin
                    crc_err_d = 1'b1;
                    state_d   = ST_HUNT;
                    ack_cnt_d = '0;
                    fas_sr_d  = '0;
                end
`endif
            end
            ST_ACK_DRAIN: begin
                if (pyld_valid && i_pyld_data_ready) begin
                    if (drain_idx_q == LAST_IDX) begin
                        drain_done_d = 1'b1;
                    end else begin
                        drain_idx_d = drain_idx_q + IDX_W'(1);
                    end
                end
                // leave only when both the ACK window and the drain are finished
                if ((ack_cnt_d == '0) && drain_done_d) begin
                    state_d  = ST_HUNT;
                    fas_sr_d = '0;
                end
            end
            default: begin
                state_d  = ST_HUNT;
                fas_sr_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_HUNT;
            fas_sr_q     <= '0;
            bit_cnt_q    <= '0;
            byte_sr_q    <= '0;
            byte_idx_q   <= '0;
            crc_val_q    <= '0;
            ack_cnt_q    <= '0;
            drain_idx_q  <= '0;
            drain_done_q <= 1'b0;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
            rx_crc_q     <= '0;
            crc_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fas_sr_q     <= fas_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_sr_q    <= byte_sr_d;
            byte_idx_q   <= byte_idx_d;
            crc_val_q    <= crc_val_d;
            ack_cnt_q    <= ack_cnt_d;
            drain_idx_q  <= drain_idx_d;
            drain_done_q <= drain_done_d;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
            rx_crc_q     <= rx_crc_d;
            crc_err_q    <= crc_err_d;
`endif
        end
    end

    // payload storage needs no reset; the output mux below masks it
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            buf_q[byte_idx_q] <= rx_byte;
        end
    end

    assign o_otn_tx_ack      = (ack_cnt_q != '0);
    assign o_pyld_data_valid = pyld_valid;
    assign o_pyld_data       = pyld_valid ? buf_q[drain_idx_q] : 8'h00;
    assign o_crc_val         = crc_val_q;
    assign o_in_frame        = (state_q == ST_PYLD) || (state_q == ST_CRC) || (state_q == ST_RESOLVE);
`ifdef RX_DEFRAMER_CRC_CHECK_EN
    assign o_crc_err         = crc_err_q;
`else
    assign o_crc_err         = 1'b0;
`endif

endmodule

// File: tb/tb_rx_deframer.sv
// tb/tb_rx_deframer.sv - directed self-checking bench for rx_deframer (PYLD_BYTES=9, ACK_CYCLES=16)
module tb_rx_deframer;

    localparam logic [47:0] FAS     = 48'hF6F6F6282828;
    localparam logic [47:0] FAS_BAD = 48'hF6F6F6282829;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b0;
    logic       ready = 1'b1;
    logic       ack;
    logic [7:0] pdata;
    logic       pvalid;
    logic [7:0] crc_val;
    logic       crc_err;
    logic       in_frame;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] payload [9];
    logic [7:0] got_q [$];
    int   ack_len, ack_runs, last_ack_len, err_cycles, hold_viol;
    logic valid_at_ack_fall, stall_seen, prev_stall;
    logic [7:0] stall_data, prev_data;

    always #5 clk = ~clk;

    rx_deframer #(.PYLD_BYTES(9), .ACK_CYCLES(16)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_otn_rx_data     (rx),
        .o_otn_tx_ack      (ack),
        .o_pyld_data       (pdata),
        .o_pyld_data_valid (pvalid),
        .i_pyld_data_ready (ready),
        .o_crc_val         (crc_val),
        .o_crc_err         (crc_err),
        .o_in_frame        (in_frame)
    );

    // observe outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (pvalid && ready) got_q.push_back(pdata);
        if (crc_err) err_cycles++;
        if (ack) begin
            ack_len++;
        end else if (ack_len != 0) begin
            ack_runs++;
            last_ack_len = ack_len;
            valid_at_ack_fall = pvalid;
            ack_len = 0;
        end
        if (prev_stall && (!pvalid || pdata !== prev_data)) hold_viol++;
        if (pvalid && !ready && !stall_seen) begin
            stall_seen = 1'b1;
            stall_data = pdata;
        end
        prev_stall = pvalid && !ready;
        prev_data  = pdata;
    end

    task automatic clear_mon();
        got_q.delete();
        ack_len = 0; ack_runs = 0; last_ack_len = 0; err_cycles = 0; hold_viol = 0;
        valid_at_ack_fall = 1'b0; stall_seen = 1'b0; prev_stall = 1'b0;
        stall_data = 8'h00; prev_data = 8'h00;
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_frame(input logic [47:0] fas, input logic [7:0] crc);
        for (int i = 47; i >= 0; i--) send_bit(fas[i]);
        for (int i = 0; i < 9; i++) send_byte(payload[i]);
        send_byte(crc);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((ack || pvalid || in_frame) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tests_run++;
        if (n >= 300) begin
            tests_failed++;
            $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic check_bytes(input string name);
        logic [7:0] b;
        tests_run++;
        if (got_q.size() !== 9) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d bytes, expected 9", name, got_q.size());
        end
        for (int i = 0; i < 9; i++) begin
            b = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++;
            if (b !== payload[i]) begin
                tests_failed++;
                $display("FAIL %s_byte%0d: got %h, expected %h", name, i, b, payload[i]);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #3;
        tests_run++;
        if ({ack, pvalid, pdata, crc_val, crc_err, in_frame} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ack=%b valid=%b data=%h crc=%h err=%b inf=%b, expected all 0",
                     ack, pvalid, pdata, crc_val, crc_err, in_frame);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_good_frame();
        clear_mon();
        send_frame(FAS, 8'hF4);
        wait_idle("good");
        tests_run++;
        if (crc_val !== 8'hF4) begin
            tests_failed++;
            $display("FAIL good_crc_val: got %h, expected f4", crc_val);
        end
        tests_run++;
        if (err_cycles !== 0) begin
            tests_failed++;
            $display("FAIL good_crc_err: got %0d pulse cycles, expected 0", err_cycles);
        end
        tests_run++;
        if (ack_runs !== 1 || last_ack_len !== 16) begin
            tests_failed++;
            $display("FAIL good_ack: got %0d runs len %0d, expected 1 run len 16", ack_runs, last_ack_len);
        end
        check_bytes("good");
    endtask

    task automatic test_crc_bad();
        clear_mon();
        send_frame(FAS, 8'hF5);
        wait_idle("bad");
        tests_run++;
        if (crc_val !== 8'hF4) begin
            tests_failed++;
            $display("FAIL bad_crc_val: got %h, expected f4", crc_val);
        end
`ifdef RX_DEFRAMER_CRC_CHECK_EN
        tests_run++;
        if (err_cycles !== 1) begin
            tests_failed++;
            $display("FAIL bad_crc_err: got %0d pulse cycles, expected 1", err_cycles);
        end
        tests_run++;
        if (ack_runs !== 0) begin
            tests_failed++;
            $display("FAIL bad_no_ack: got %0d ack runs, expected 0", ack_runs);
        end
        tests_run++;
        if (got_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL bad_no_bytes: got %0d bytes, expected 0", got_q.size());
        end
`else
        tests_run++;
        if (err_cycles !== 0) begin
            tests_failed++;
            $display("FAIL bad_crc_err: got %0d pulse cycles, expected 0", err_cycles);
        end
        tests_run++;
        if (ack_runs !== 1 || last_ack_len !== 16) begin
            tests_failed++;
            $display("FAIL bad_ack: got %0d runs len %0d, expected 1 run len 16", ack_runs, last_ack_len);
        end
        check_bytes("bad");
`endif
    endtask

    task automatic test_ready_stall();
        clear_mon();
        ready = 1'b0;
        send_frame(FAS, 8'hF4);
        repeat (40) @(posedge clk);
        #1 ready = 1'b1;
        wait_idle("stall");
        tests_run++;
        if (ack_runs !== 1 || last_ack_len !== 16) begin
            tests_failed++;
            $display("FAIL stall_ack: got %0d runs len %0d, expected 1 run len 16", ack_runs, last_ack_len);
        end
        tests_run++;
        if (stall_data !== 8'h31) begin
            tests_failed++;
            $display("FAIL stall_first_byte: got %h, expected 31", stall_data);
        end
        tests_run++;
        if (hold_viol !== 0) begin
            tests_failed++;
            $display("FAIL stall_hold: got %0d changes while stalled, expected 0", hold_viol);
        end
        tests_run++;
        if (valid_at_ack_fall !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_drain_outlives_ack: valid=%b at ACK end, expected 1", valid_at_ack_fall);
        end
        check_bytes("stall");
    endtask

    task automatic test_hunt_noise();
        clear_mon();
        for (int i = 0; i < 200; i++) send_bit(1'($urandom_range(0, 1)));
        send_frame(FAS_BAD, 8'hF4);
        send_frame(FAS, 8'hF4);
        wait_idle("noise");
        tests_run++;
        if (ack_runs !== 1 || last_ack_len !== 16) begin
            tests_failed++;
            $display("FAIL noise_ack: got %0d runs len %0d, expected 1 run len 16", ack_runs, last_ack_len);
        end
        check_bytes("noise");
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int i = 47; i >= 0; i--) send_bit(FAS[i]);
        for (int i = 0; i < 4; i++) send_byte(payload[i]);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({ack, pvalid, pdata, crc_val, crc_err, in_frame} !== 20'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got ack=%b valid=%b data=%h crc=%h err=%b inf=%b, expected all 0",
                     ack, pvalid, pdata, crc_val, crc_err, in_frame);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 4; i < 9; i++) send_byte(payload[i]);
        send_byte(8'hF4);
        repeat (30) @(negedge clk);
        tests_run++;
        if (got_q.size() !== 0 || ack_runs !== 0) begin
            tests_failed++;
            $display("FAIL midrst_silent: got %0d bytes %0d acks, expected 0 and 0", got_q.size(), ack_runs);
        end
        clear_mon();
        send_frame(FAS, 8'hF4);
        wait_idle("after_rst");
        tests_run++;
        if (crc_val !== 8'hF4 || ack_runs !== 1 || last_ack_len !== 16) begin
            tests_failed++;
            $display("FAIL after_rst_frame: got crc %h runs %0d len %0d, expected f4 1 16", crc_val, ack_runs, last_ack_len);
        end
        check_bytes("after_rst");
    endtask

`ifndef RX_DEFRAMER_CRC_CHECK_EN
    task automatic test_crc_off();
        clear_mon();
        send_frame(FAS, 8'h00);
        wait_idle("crcoff");
        tests_run++;
        if (crc_val !== 8'hF4 || err_cycles !== 0) begin
            tests_failed++;
            $display("FAIL crcoff_crc: got crc %h err %0d, expected f4 0", crc_val, err_cycles);
        end
        tests_run++;
        if (ack_runs !== 1 || last_ack_len !== 16) begin
            tests_failed++;
            $display("FAIL crcoff_ack: got %0d runs len %0d, expected 1 run len 16", ack_runs, last_ack_len);
        end
        check_bytes("crcoff");
    endtask
`endif

    initial begin
        for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
        clear_mon();
        test_reset();
        test_good_frame();
        test_crc_bad();
        test_ready_stall();
        test_hunt_noise();
        test_reset_mid();
`ifndef RX_DEFRAMER_CRC_CHECK_EN
        test_crc_off();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
